axi4_lite_slv_reg_file: RTL
===========================

# axi4_lite_slv_reg_file

AXI4-Lite slave that terminates the slave side of an `aix4_lite_if` and exposes a bank of read/write control registers to fabric logic. It is the responder counterpart of the team's AXI4-Lite master path and is the DUT for the register-model trial bench. Write and read channels run independently, with at most one outstanding transaction per direction.

## Interface
- `ADDR_BIT_WIDTH`, 4: AXI address width. Must be ≥ log2(`DATA_BIT_WIDTH`/8) + clog2(`N_REGS`).
- `DATA_BIT_WIDTH`, 32: AXI data width. Legal values: 32 or 64.
- `N_REGS`, 4: number of registers. Legal range: 1..2^(ADDR_BIT_WIDTH − log2(DATA_BIT_WIDTH/8)).
- `i_clk` input 1: clock. All logic is rising-edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `if_s_axi` interface `aix4_lite_if.slv_port`: AXI4-Lite slave port. Its parameters match the module's.
- `o_regs` output `[N_REGS][DATA_BIT_WIDTH]`: current register contents.
- `o_wr_pulse` output `N_REGS`: one-cycle pulse on the cycle after a write commits to that register.

## Operation
- Decode: word index = addr >> log2(DATA_BIT_WIDTH/8). The low byte-offset bits are ignored. An address is mapped when index < `N_REGS`. `awprot` and `arprot` are ignored.
- Write channel uses two held flags, `aw_held` and `w_held`, plus `bvalid`.
  - `awready` = !aw_held && !bvalid.
  - `wready` = !w_held && !bvalid.
  - An AW handshake latches the address. A W handshake latches data and strobe. AW and W may arrive in either order or in the same cycle.
  - Commit happens at the first edge where both flags are set and `bvalid` = 0. For a mapped address, byte lanes with wstrb[i] = 1 are written. Also at that edge: `bvalid` ← 1, `bresp` set, and the flags are cleared.
  - `bvalid` stays high until `bready`. It drops on the handshake edge.
- Read channel:
  - `arready` = !rvalid.
  - On the AR handshake edge, `rdata` and `rresp` are registered and `rvalid` ← 1.
  - `rvalid`, `rdata` and `rresp` hold until the `rready` handshake.
  - An unmapped read returns `rdata` = 0.
- Same-edge AR handshake and write commit to the same register: the read returns the pre-write value.
- Reset values:
  - All registers = 0.
  - `bvalid`, `rvalid` and `o_wr_pulse` = 0.
  - `bresp` and `rresp` = 2'b00.
  - `rdata` = 0.
  - `awready`, `wready` and `arready` = 1 (combinational from reset state).
- Reset asserted mid-transaction: pending AW/W data and any unsent response are discarded. No commit occurs.

## Timing
- Write latency: `bvalid` rises one cycle after the later of the AW and W handshakes. The register and `o_regs` update on the same edge. `o_wr_pulse` is high for the following cycle.
- Fastest write throughput: handshake at edge T, commit/`bvalid` at T+1, `bready` handshake at T+2, next handshake at T+3.
- Read latency: `rvalid` is high in the cycle after the AR handshake. With `rready` held high, one read completes every 2 cycles.
- Neither channel blocks the other.

## Configuration
- `AXI4_LITE_SLV_REG_FILE_SLVERR_EN` defined:
  - Unmapped write: `bresp` = SLVERR (2'b10), no register changes.
  - Unmapped read: `rresp` = SLVERR, `rdata` = 0.
- Not defined: unmapped accesses return OKAY (2'b00). Writes are silently dropped and reads return 0.
- Mapped accesses always return OKAY.

## Structure
- Shared package `axi4_lite_pkg` holds:
  - the `axi4_lite_resp_t` enum: OKAY = 00, EXOKAY = 01, SLVERR = 10, DECERR = 11;
  - a function computing the word-index shift from `DATA_BIT_WIDTH`.
- One sub-module, `axi4_lite_slv_wr_ctrl`, contains the AW/W join, held flags and B-channel logic. It outputs commit strobe, index, data and strobe. The top contains the register array, read channel and decode.

## Test plan
- AW (addr 0x4) and W (data 0xDEADBEEF, wstrb 0xF) in the same cycle, `bready` = 1 → `bvalid` next cycle with OKAY; `o_regs[1]` = 0xDEADBEEF; `o_wr_pulse` = 4'b0010 for one cycle.
- W first (data 0x11223344, wstrb 4'b0101), AW to 0x8 three cycles later, starting from reg2 = 0 → `wready` low while waiting; reg2 = 0x00220044; `bvalid` one cycle after the AW handshake.
- `bready` held low for 5 cycles → `bvalid` and `bresp` stable; `awready`/`wready` low; a new AW is not accepted until the cycle after the B handshake.
- Read 0x4 after the first test, `rready` low for 3 cycles → `rvalid` stable with `rdata` 0xDEADBEEF, OKAY; `arready` low until the handshake.
- Write and read to 0xC (N_REGS = 4 mapped) plus a directed access with `N_REGS` = 3 → with the macro: SLVERR and `rdata` 0; without it: OKAY, no register change.
- Assert `i_rst_n` after an AW handshake, before W → no commit; all registers 0; readies high; `bvalid` 0 after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response encoding and word-index helper
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4_lite_resp_t;

    // Number of byte-offset address bits dropped to form a register index.
    function automatic int word_shift(input int data_bit_width);
        return $clog2(data_bit_width / 8);
    endfunction

endpackage

// File: rtl/aix4_lite_if.sv
// rtl/aix4_lite_if.sv - AXI4-Lite bundle with master and slave views
interface aix4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slv_port (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport mst_port (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slv_wr_ctrl.sv
// rtl/axi4_lite_slv_wr_ctrl.sv - AW/W join with held flags, commit strobe and B channel
module axi4_lite_slv_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int IDX_W          = 2,
    parameter bit SLVERR_EN      = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [IDX_W-1:0]            awidx_i,
    input  logic                        awvalid_i,
    output logic                        awready_o,
    input  logic [DATA_BIT_WIDTH-1:0]   wdata_i,
    input  logic [DATA_BIT_WIDTH/8-1:0] wstrb_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    output logic [1:0]                  bresp_o,
    output logic                        bvalid_o,
    input  logic                        bready_i,
    input  logic                        wr_mapped_i,
    output logic                        commit_o,
    output logic [IDX_W-1:0]            idx_o,
    output logic [DATA_BIT_WIDTH-1:0]   data_o,
    output logic [DATA_BIT_WIDTH/8-1:0] strb_o
);
    logic                        aw_held_q;
    logic                        w_held_q;
    logic                        bvalid_q;
    axi4_lite_resp_t             bresp_q;
    logic [IDX_W-1:0]            idx_q;
    logic [DATA_BIT_WIDTH-1:0]   data_q;
    logic [DATA_BIT_WIDTH/8-1:0] strb_q;

    // A pending response blocks both address and data acceptance.
    assign awready_o = !aw_held_q && !bvalid_q;
    assign wready_o  = !w_held_q && !bvalid_q;
    assign commit_o  = aw_held_q && w_held_q && !bvalid_q;

    assign bvalid_o = bvalid_q;
    assign bresp_o  = bresp_q;
    assign idx_o    = idx_q;
    assign data_o   = data_q;
    assign strb_o   = strb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_held_q <= 1'b1;
                idx_q     <= awidx_i;
            end
            if (wvalid_i && wready_o) begin
                w_held_q <= 1'b1;
                data_q   <= wdata_i;
                strb_q   <= wstrb_i;
            end
            if (commit_o) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= (wr_mapped_i || !SLVERR_EN) ? OKAY : SLVERR;
            end else if (bvalid_q && bready_i) begin
                bvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// rtl/axi4_lite_slv_reg_file.sv - AXI4-Lite register bank; AXI4_LITE_SLV_REG_FILE_SLVERR_EN flags unmapped access
module axi4_lite_slv_reg_file
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int N_REGS         = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    aix4_lite_if.slv_port                         if_s_axi,
    output logic [N_REGS-1:0][DATA_BIT_WIDTH-1:0] o_regs,
    output logic [N_REGS-1:0]                     o_wr_pulse
);
    localparam int SHIFT  = word_shift(DATA_BIT_WIDTH);
    localparam int IDX_W  = ADDR_BIT_WIDTH - SHIFT;
    localparam int STRB_W = DATA_BIT_WIDTH / 8;
`ifdef AXI4_LITE_SLV_REG_FILE_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic [N_REGS-1:0][DATA_BIT_WIDTH-1:0] regs_q;
    logic [N_REGS-1:0]                     wr_pulse_q;
    logic                                  wr_commit;
    logic                                  wr_mapped;
    logic [IDX_W-1:0]                      wr_idx;
    logic [DATA_BIT_WIDTH-1:0]             wr_data;
    logic [STRB_W-1:0]                     wr_strb;
    logic [IDX_W-1:0]                      rd_idx;
    logic                                  rd_mapped;
    logic                                  rd_hs;
    logic [DATA_BIT_WIDTH-1:0]             rd_word;
    logic                                  rvalid_q;
    logic [DATA_BIT_WIDTH-1:0]             rdata_q;
    axi4_lite_resp_t                       rresp_q;

    axi4_lite_slv_wr_ctrl #(
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
        .IDX_W          (IDX_W),
        .SLVERR_EN      (SLVERR_EN)
    ) u_wr_ctrl (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .awidx_i     (if_s_axi.awaddr[ADDR_BIT_WIDTH-1:SHIFT]),
        .awvalid_i   (if_s_axi.awvalid),
        .awready_o   (if_s_axi.awready),
        .wdata_i     (if_s_axi.wdata),
        .wstrb_i     (if_s_axi.wstrb),
        .wvalid_i    (if_s_axi.wvalid),
        .wready_o    (if_s_axi.wready),
        .bresp_o     (if_s_axi.bresp),
        .bvalid_o    (if_s_axi.bvalid),
        .bready_i    (if_s_axi.bready),
        .wr_mapped_i (wr_mapped),
        .commit_o    (wr_commit),
        .idx_o       (wr_idx),
        .data_o      (wr_data),
        .strb_o      (wr_strb)
    );

    assign wr_mapped = 32'(wr_idx) < N_REGS;
    assign rd_idx    = if_s_axi.araddr[ADDR_BIT_WIDTH-1:SHIFT];
    assign rd_mapped = 32'(rd_idx) < N_REGS;
    assign rd_hs     = if_s_axi.arvalid && !rvalid_q;

    // Unmapped indices match no entry, so reads of them return zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                wr_pulse_q[i] <= wr_commit && (wr_idx == IDX_W'(i));
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_commit && (wr_idx == IDX_W'(i)) && wr_strb[b])
                        regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= (rd_mapped || !SLVERR_EN) ? OKAY : SLVERR;
            end else if (rvalid_q && if_s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign if_s_axi.arready = !rvalid_q;
    assign if_s_axi.rvalid  = rvalid_q;
    assign if_s_axi.rdata   = rdata_q;
    assign if_s_axi.rresp   = rresp_q;
    assign o_regs           = regs_q;
    assign o_wr_pulse       = wr_pulse_q;
endmodule
